// File: rtl/tlb_l2_walk_ctrl.sv
// tlb_l2_walk_ctrl: initiator side of the L2 TLB lookup path.
// Takes one L1 TLB miss at a time and drives the L2 lookup port across the
// hash-rehash cycles. An L2 miss becomes a page-table walk request. The refill
// goes back to the L1 over a valid/ready handshake.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               abort the in-flight request
//   req_*                 L1 miss request (valid/ready, asid, vaddr)
//   l2_*                  L2 lookup strobe, captured asid/vaddr, L2 results
//   ptw_*                 walk request handshake, walk-in-progress, PTW result
//   rsp_o, rsp_ready_i    refill to the L1 (rsp_o.valid is the response valid)
//   rsp_error_o           refill carries a walk error
//   hit_cnt_o, miss_cnt_o saturating L2-hit / walk-request counters
//   proto_err_o           sticky: L2 never reported all hashes checked

package tlb_l2_walk_pkg;
   localparam int unsigned VLEN     = 39;
   localparam int unsigned ASID_MAX = 16;

   typedef struct packed {
      logic [9:0]  reserved;
      logic [43:0] ppn;
      logic [1:0]  rsw;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } pte_t;

   typedef struct packed {
      logic                valid;
      logic                is_2M;
      logic                is_1G;
      logic [26:0]         vpn;
      logic [ASID_MAX-1:0] asid;
      pte_t                content;
   } tlb_update_t;
endpackage

// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready for the next L1 miss
// S_LOOKUP  | strobing the L2 until it reports all hashes checked
// S_PTW_REQ | presenting the walk request to the PTW
// S_PTW_WAIT| walk accepted, waiting for the PTW update
// S_RESP    | refill held on rsp_o until the L1 takes it
module tlb_l2_walk_ctrl
   import tlb_l2_walk_pkg::*;
#(
   parameter int unsigned ASID_WIDTH = 1,
   parameter int unsigned MAX_LOOKUP = 3,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ASID_WIDTH-1:0] req_asid_i,
   input  logic [VLEN-1:0]       req_vaddr_i,
   output logic                  l2_access_o,
   output logic [ASID_WIDTH-1:0] l2_asid_o,
   output logic [VLEN-1:0]       l2_vaddr_o,
   input  logic                  l2_hit_i,
   input  logic                  l2_all_checked_i,
   input  pte_t                  l2_content_i,
   input  logic                  l2_is_2M_i,
   input  logic                  l2_is_1G_i,
   output logic                  ptw_active_o,
   output logic                  ptw_req_valid_o,
   input  logic                  ptw_req_ready_i,
   output logic [VLEN-1:0]       ptw_vaddr_o,
   input  tlb_update_t           ptw_update_i,
   input  logic                  ptw_error_i,
   output tlb_update_t           rsp_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_error_o,
   output logic [CNT_WIDTH-1:0]  hit_cnt_o,
   output logic [CNT_WIDTH-1:0]  miss_cnt_o,
   output logic                  proto_err_o
);

   localparam int unsigned LW = $clog2(MAX_LOOKUP + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_PTW_REQ,
      S_PTW_WAIT,
      S_RESP
   } state_e;

   state_e state_q, state_d;

   logic [ASID_WIDTH-1:0] asid_q;
   logic [VLEN-1:0]       vaddr_q;
   logic [LW-1:0]         lookup_cnt_q;
   logic                  abort_q, abort_d;
   pte_t                  content_q;
   logic                  is_2M_q, is_1G_q, err_q;
   logic [CNT_WIDTH-1:0]  hit_cnt_q, miss_cnt_q;
   logic                  proto_err_q;

   logic cap_req, cap_l2, cap_ptw, inc_hit, inc_miss, set_proto;
   logic abort_now, lookup_timeout;

   // The vpn/asid of the PTW update are implied by the captured request.
   logic unused_upd_fields;
   assign unused_upd_fields = ^{ptw_update_i.vpn, ptw_update_i.asid};

   assign abort_now      = abort_q | flush_i;
   assign lookup_timeout = (lookup_cnt_q == LW'(MAX_LOOKUP - 1)) && !l2_all_checked_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      abort_d   = abort_q;
      cap_req   = 1'b0;
      cap_l2    = 1'b0;
      cap_ptw   = 1'b0;
      inc_hit   = 1'b0;
      inc_miss  = 1'b0;
      set_proto = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               cap_req = 1'b1;
               abort_d = 1'b0;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            // An abort keeps the lookup running to completion so the L2 hash
            // sequence is never cut short.
            abort_d = abort_now;
            if (l2_all_checked_i) begin
               if (abort_now) begin
                  state_d = S_IDLE;
               end else if (l2_hit_i) begin
                  cap_l2  = 1'b1;
                  inc_hit = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_PTW_REQ;
               end
            end else if (lookup_timeout) begin
               set_proto = 1'b1;
               state_d   = abort_now ? S_IDLE : S_PTW_REQ;
            end
         end
         S_PTW_REQ: begin
            if (ptw_req_ready_i) begin
               // A flush racing the handshake cannot retract the walk.
               inc_miss = 1'b1;
               abort_d  = flush_i;
               state_d  = S_PTW_WAIT;
            end else if (flush_i) begin
               state_d = S_IDLE;
            end
         end
         S_PTW_WAIT: begin
            abort_d = abort_now;
            if (ptw_update_i.valid) begin
               if (abort_now) begin
                  state_d = S_IDLE;
               end else begin
                  cap_ptw = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (flush_i || rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         asid_q       <= '0;
         vaddr_q      <= '0;
         lookup_cnt_q <= '0;
         abort_q      <= 1'b0;
         content_q    <= '0;
         is_2M_q      <= 1'b0;
         is_1G_q      <= 1'b0;
         err_q        <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         proto_err_q  <= 1'b0;
      end else begin
         abort_q <= abort_d;
         if (cap_req) begin
            asid_q       <= req_asid_i;
            vaddr_q      <= req_vaddr_i;
            lookup_cnt_q <= '0;
         end else if (state_q == S_LOOKUP) begin
            lookup_cnt_q <= lookup_cnt_q + LW'(1);
         end
         if (cap_l2) begin
            content_q <= l2_content_i;
            is_2M_q   <= l2_is_2M_i;
            is_1G_q   <= l2_is_1G_i;
            err_q     <= 1'b0;
         end else if (cap_ptw) begin
            content_q <= ptw_update_i.content;
            is_2M_q   <= ptw_update_i.is_2M;
            is_1G_q   <= ptw_update_i.is_1G;
            err_q     <= ptw_error_i;
         end
         if (inc_hit && (hit_cnt_q != '1)) begin
            hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
         end
         if (inc_miss && (miss_cnt_q != '1)) begin
            miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
         end
         if (set_proto) begin
            proto_err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      req_ready_o     = (state_q == S_IDLE);
      l2_access_o     = (state_q == S_LOOKUP);
      l2_asid_o       = asid_q;
      l2_vaddr_o      = vaddr_q;
      ptw_req_valid_o = (state_q == S_PTW_REQ);
      ptw_active_o    = (state_q == S_PTW_REQ) || (state_q == S_PTW_WAIT);
      ptw_vaddr_o     = vaddr_q;
      rsp_o           = '0;
      rsp_error_o     = 1'b0;
      if (state_q == S_RESP) begin
         rsp_o.valid                = 1'b1;
         rsp_o.is_2M                = is_2M_q;
         rsp_o.is_1G                = is_1G_q;
         rsp_o.vpn                  = vaddr_q[VLEN-1:12];
         rsp_o.asid[ASID_WIDTH-1:0] = asid_q;
         rsp_o.content              = content_q;
         rsp_error_o                = err_q;
      end
      hit_cnt_o   = hit_cnt_q;
      miss_cnt_o  = miss_cnt_q;
      proto_err_o = proto_err_q;
   end

endmodule
